// File: rtl/processor_status_unit.sv
// 6502 processor status register (N V D I Z C) with per-flag commands, PLP/RTI load,
// instruction-boundary-delayed IRQ mask and a hardware shadow stack for interrupt entry/exit.
module processor_status_unit #(
  parameter int   WIDTH        = 8,
  parameter int   SHADOW_DEPTH = 4,
  parameter logic RESET_I      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             update_c,
  input  logic             update_z,
  input  logic             update_n,
  input  logic             update_v,
  input  logic [7:0]       flag_set,
  input  logic [7:0]       flag_clear,
  input  logic             load_p,
  input  logic [7:0]       p_in,
  input  logic             push_brk,
  input  logic             instr_done,
  input  logic             shadow_push,
  input  logic             shadow_pop,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_i,
  output logic             flag_d,
  output logic             flag_v,
  output logic             flag_n,
  output logic [7:0]       p_out,
  output logic             irq_mask,
  output logic             shadow_full,
  output logic             shadow_empty,
  output logic             shadow_overflow,
  output logic             shadow_underflow
);

  localparam int             CW         = $clog2(SHADOW_DEPTH + 1);
  localparam logic [CW-1:0]  FULL_COUNT = CW'(SHADOW_DEPTH);
  localparam int unsigned    BIT_I      = 2;

  // Internal 6-bit flag image, LSB first: C, Z, I, D, V, N
  logic [5:0]    p_q;
  logic [5:0]    p_d;
  logic [5:0]    set_vec;
  logic [5:0]    clr_vec;
  logic [5:0]    upd_en;
  logic [5:0]    upd_val;
  logic [5:0]    p_image;
  logic [CW-1:0] count_q;
  logic [CW-1:0] top;
  logic [5:0]    stack [2**CW];
  logic          push_only;
  logic          pop_only;
  logic          push_ok;
  logic          pop_ok;
  logic          mask_q;
  logic          ovf_q;
  logic          unf_q;
  logic          unused_bits;

  assign set_vec = {flag_set[7], flag_set[6], flag_set[3], flag_set[2], flag_set[1], flag_set[0]};
  assign clr_vec = {flag_clear[7], flag_clear[6], flag_clear[3], flag_clear[2], flag_clear[1], flag_clear[0]};
  assign p_image = {p_in[7], p_in[6], p_in[3], p_in[2], p_in[1], p_in[0]};
  assign upd_en  = {update_n, update_v, 2'b00, update_z, update_c};
  assign upd_val = {data_in[WIDTH-1], overflow_in, 2'b00, ~|data_in, carry_in};

  assign unused_bits = ^{flag_set[5:4], flag_clear[5:4], p_in[5:4]};

  assign shadow_full  = (count_q == FULL_COUNT);
  assign shadow_empty = (count_q == '0);

  // Simultaneous push and pop cancel out entirely.
  assign push_only = shadow_push & ~shadow_pop;
  assign pop_only  = shadow_pop & ~shadow_push;
  assign push_ok   = push_only & ~shadow_full;
  assign pop_ok    = pop_only & ~shadow_empty;
  assign top       = count_q - CW'(1);

  // Lowest priority applied first; later assignments override.
  always_comb begin
    p_d = (p_q & ~upd_en) | (upd_val & upd_en);
    p_d = p_d & ~clr_vec;
    p_d = p_d | set_vec;
    if (push_only) p_d[BIT_I] = 1'b1;
    if (load_p)    p_d = p_image;
    if (pop_ok)    p_d = stack[top];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q     <= {3'b000, RESET_I, 2'b00};
      count_q <= '0;
      mask_q  <= RESET_I;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      p_q <= p_d;
      if (push_ok)
        count_q <= count_q + CW'(1);
      else if (pop_ok)
        count_q <= top;
      if (push_only && shadow_full)
        ovf_q <= 1'b1;
      if (pop_only && shadow_empty)
        unf_q <= 1'b1;
      if (instr_done)
        mask_q <= p_q[BIT_I];
    end
  end

  // Stack contents need no reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      stack[count_q] <= p_q;
  end

  assign flag_c = p_q[0];
  assign flag_z = p_q[1];
  assign flag_i = p_q[2];
  assign flag_d = p_q[3];
  assign flag_v = p_q[4];
  assign flag_n = p_q[5];

  assign p_out            = {p_q[5], p_q[4], 1'b1, push_brk, p_q[3], p_q[2], p_q[1], p_q[0]};
  assign irq_mask         = mask_q;
  assign shadow_overflow  = ovf_q;
  assign shadow_underflow = unf_q;

endmodule

// File: tb/tb_processor_status_unit.sv
// Directed bench for processor_status_unit (WIDTH=16, SHADOW_DEPTH=2, RESET_I=1).
module tb_processor_status_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        carry_in, overflow_in;
  logic        update_c, update_z, update_n, update_v;
  logic [7:0]  flag_set, flag_clear;
  logic        load_p;
  logic [7:0]  p_in;
  logic        push_brk, instr_done, shadow_push, shadow_pop;
  logic        flag_c, flag_z, flag_i, flag_d, flag_v, flag_n;
  logic [7:0]  p_out;
  logic        irq_mask, shadow_full, shadow_empty, shadow_overflow, shadow_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  processor_status_unit #(.WIDTH(16), .SHADOW_DEPTH(2), .RESET_I(1'b1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .carry_in(carry_in), .overflow_in(overflow_in),
    .update_c(update_c), .update_z(update_z), .update_n(update_n), .update_v(update_v),
    .flag_set(flag_set), .flag_clear(flag_clear), .load_p(load_p), .p_in(p_in),
    .push_brk(push_brk), .instr_done(instr_done), .shadow_push(shadow_push), .shadow_pop(shadow_pop),
    .flag_c(flag_c), .flag_z(flag_z), .flag_i(flag_i), .flag_d(flag_d), .flag_v(flag_v), .flag_n(flag_n),
    .p_out(p_out), .irq_mask(irq_mask), .shadow_full(shadow_full), .shadow_empty(shadow_empty),
    .shadow_overflow(shadow_overflow), .shadow_underflow(shadow_underflow)
  );

  task automatic idle_inputs();
    reset = 1'b0; data_in = '0; carry_in = 1'b0; overflow_in = 1'b0;
    update_c = 1'b0; update_z = 1'b0; update_n = 1'b0; update_v = 1'b0;
    flag_set = '0; flag_clear = '0; load_p = 1'b0; p_in = '0;
    push_brk = 1'b0; instr_done = 1'b0; shadow_push = 1'b0; shadow_pop = 1'b0;
  endtask

  // Advance one edge, then return inputs to idle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    shadow_push = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_inputs();
    checks++; if ({flag_n, flag_v, flag_d, flag_i, flag_z, flag_c} !== 6'b000100) begin errors++;
      $display("FAIL reset_flags got %b want %b", {flag_n, flag_v, flag_d, flag_i, flag_z, flag_c}, 6'b000100); end
    checks++; if (irq_mask !== 1'b1) begin errors++; $display("FAIL reset_irq_mask got %b want 1", irq_mask); end
    checks++; if ({shadow_empty, shadow_full} !== 2'b10) begin errors++;
      $display("FAIL reset_occupancy got empty/full %b want 10", {shadow_empty, shadow_full}); end
    checks++; if ({shadow_overflow, shadow_underflow} !== 2'b00) begin errors++;
      $display("FAIL reset_errors got %b want 00", {shadow_overflow, shadow_underflow}); end
    checks++; if (p_out !== 8'h24) begin errors++; $display("FAIL reset_p_out got %h want 24", p_out); end
    push_brk = 1'b1; #1;
    checks++; if (p_out !== 8'h34) begin errors++; $display("FAIL reset_p_out_brk got %h want 34", p_out); end
    push_brk = 1'b0;
  endtask

  task automatic test_update_zn();
    data_in = 16'h8000; update_z = 1'b1; update_n = 1'b1;
    tick();
    checks++; if ({flag_z, flag_n} !== 2'b01) begin errors++; $display("FAIL zn_8000 got zn=%b want 01", {flag_z, flag_n}); end
    data_in = 16'h0000; update_z = 1'b1; update_n = 1'b1;
    tick();
    checks++; if ({flag_z, flag_n} !== 2'b10) begin errors++; $display("FAIL zn_0000 got zn=%b want 10", {flag_z, flag_n}); end
    data_in = 16'h0080; update_z = 1'b1; update_n = 1'b1;
    tick();
    checks++; if ({flag_z, flag_n} !== 2'b00) begin errors++; $display("FAIL zn_0080 got zn=%b want 00", {flag_z, flag_n}); end
  endtask

  task automatic test_priority();
    flag_set = 8'h01; flag_clear = 8'h01; update_c = 1'b1; carry_in = 1'b0;
    tick();
    checks++; if (flag_c !== 1'b1) begin errors++; $display("FAIL set_beats_clear got c=%b want 1", flag_c); end
    flag_clear = 8'h01; update_c = 1'b1; carry_in = 1'b1;
    tick();
    checks++; if (flag_c !== 1'b0) begin errors++; $display("FAIL clear_beats_update got c=%b want 0", flag_c); end
    update_c = 1'b1; carry_in = 1'b1; update_v = 1'b1; overflow_in = 1'b1;
    tick();
    checks++; if ({flag_v, flag_c} !== 2'b11) begin errors++; $display("FAIL update_cv got vc=%b want 11", {flag_v, flag_c}); end
    flag_set = 8'h08;
    tick();
    checks++; if (flag_d !== 1'b1) begin errors++; $display("FAIL set_d got %b want 1", flag_d); end
  endtask

  task automatic test_load_p();
    load_p = 1'b1; p_in = 8'hFF; flag_clear = 8'hFF;
    tick();
    checks++; if ({flag_n, flag_v, flag_d, flag_i, flag_z, flag_c} !== 6'b111111) begin errors++;
      $display("FAIL load_ff got %b want 111111", {flag_n, flag_v, flag_d, flag_i, flag_z, flag_c}); end
    checks++; if (p_out !== 8'hEF) begin errors++; $display("FAIL load_ff_p_out got %h want ef", p_out); end
    load_p = 1'b1; p_in = 8'h30;
    tick();
    checks++; if (p_out !== 8'h20) begin errors++; $display("FAIL load_30_p_out got %h want 20", p_out); end
    checks++; if (irq_mask !== 1'b1) begin errors++; $display("FAIL mask_holds_without_boundary got %b want 1", irq_mask); end
  endtask

  task automatic test_irq_delay();
    // I=0, irq_mask=1 here; SEI together with a boundary latches the old I.
    flag_set = 8'h04; instr_done = 1'b1;
    tick();
    checks++; if ({flag_i, irq_mask} !== 2'b10) begin errors++; $display("FAIL sei_same_edge got i/mask=%b want 10", {flag_i, irq_mask}); end
    instr_done = 1'b1;
    tick();
    checks++; if (irq_mask !== 1'b1) begin errors++; $display("FAIL sei_next_boundary got %b want 1", irq_mask); end
    flag_clear = 8'h04;
    tick();
    checks++; if ({flag_i, irq_mask} !== 2'b01) begin errors++; $display("FAIL cli_t got i/mask=%b want 01", {flag_i, irq_mask}); end
    tick();
    checks++; if (irq_mask !== 1'b1) begin errors++; $display("FAIL cli_t1 got %b want 1", irq_mask); end
    instr_done = 1'b1;
    tick();
    checks++; if (irq_mask !== 1'b0) begin errors++; $display("FAIL cli_t2 got %b want 0", irq_mask); end
  endtask

  task automatic test_shadow_stack();
    load_p = 1'b1; p_in = 8'h05;
    tick();
    shadow_push = 1'b1;
    tick();
    checks++; if ({shadow_empty, shadow_full, flag_i} !== 3'b001) begin errors++;
      $display("FAIL push1 got empty/full/i=%b want 001", {shadow_empty, shadow_full, flag_i}); end
    flag_clear = 8'h01; flag_set = 8'h02;
    tick();
    shadow_push = 1'b1;
    tick();
    checks++; if (shadow_full !== 1'b1) begin errors++; $display("FAIL push2_full got %b want 1", shadow_full); end
    flag_clear = 8'h04;
    tick();
    shadow_push = 1'b1;
    tick();
    checks++; if ({shadow_overflow, flag_i, shadow_full} !== 3'b111) begin errors++;
      $display("FAIL push3_overflow got ovf/i/full=%b want 111", {shadow_overflow, flag_i, shadow_full}); end
    load_p = 1'b1; p_in = 8'hC8;
    tick();
    shadow_pop = 1'b1; flag_set = 8'h80;
    tick();
    checks++; if (p_out !== 8'h26) begin errors++; $display("FAIL pop1_restore got %h want 26", p_out); end
    shadow_pop = 1'b1;
    tick();
    checks++; if (p_out !== 8'h25) begin errors++; $display("FAIL pop2_restore got %h want 25", p_out); end
    checks++; if (shadow_empty !== 1'b1) begin errors++; $display("FAIL pop2_empty got %b want 1", shadow_empty); end
    shadow_pop = 1'b1;
    tick();
    checks++; if ({shadow_underflow, p_out} !== {1'b1, 8'h25}) begin errors++;
      $display("FAIL pop3_underflow got unf=%b p=%h want 1 25", shadow_underflow, p_out); end
    shadow_pop = 1'b1; flag_set = 8'h80;
    tick();
    checks++; if (p_out !== 8'hA5) begin errors++; $display("FAIL pop_empty_other_cmds got %h want a5", p_out); end
  endtask

  task automatic test_back_to_back();
    // Push+pop together: no stack effect, I not forced by the push.
    shadow_push = 1'b1; shadow_pop = 1'b1; flag_clear = 8'h84;
    tick();
    checks++; if ({flag_i, shadow_empty} !== 2'b01) begin errors++;
      $display("FAIL push_pop_same got i/empty=%b want 01", {flag_i, shadow_empty}); end
    checks++; if ({shadow_overflow, shadow_underflow} !== 2'b11) begin errors++;
      $display("FAIL errors_sticky got %b want 11", {shadow_overflow, shadow_underflow}); end
    shadow_push = 1'b1;
    tick();
    checks++; if ({flag_i, shadow_empty} !== 2'b10) begin errors++;
      $display("FAIL b2b_push got i/empty=%b want 10", {flag_i, shadow_empty}); end
    shadow_pop = 1'b1; flag_set = 8'h80;
    tick();
    checks++; if ({p_out, shadow_empty} !== {8'h21, 1'b1}) begin errors++;
      $display("FAIL b2b_pop got p=%h empty=%b want 21 1", p_out, shadow_empty); end
  endtask

  task automatic test_reset_again();
    shadow_push = 1'b1;
    tick();
    reset = 1'b1; shadow_pop = 1'b1; flag_set = 8'hFF;
    @(posedge clk); #1;
    idle_inputs();
    checks++; if ({shadow_empty, shadow_overflow, shadow_underflow, p_out} !== {3'b100, 8'h24}) begin errors++;
      $display("FAIL reset_midstream got empty/ovf/unf=%b p=%h want 100 24",
               {shadow_empty, shadow_overflow, shadow_underflow}, p_out); end
  endtask

  initial begin
    test_reset();
    test_update_zn();
    test_priority();
    test_load_p();
    test_irq_delay();
    test_shadow_stack();
    test_back_to_back();
    test_reset_again();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
